// File: rtl/capture_pkg.sv
// Shared types and constants for the capture controller: FSM states, buffer geometry
// and the auto-trigger timeout.
package capture_pkg;

  localparam int unsigned DEPTH           = 256;
  localparam int unsigned ADDR_W          = 8;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned CNT_W           = 9;
  localparam int unsigned AT_W            = 23;
  localparam int unsigned AUTOTRIG_CYCLES = 5000000;

  typedef enum logic [2:0] {
    StIdle,
    StPrefill,
    StArmed,
    StPost,
    StDump
  } state_e;

  // Post-trigger samples still to be written once pretrig samples precede the trigger.
  function automatic logic [CNT_W-1:0] post_len(logic [ADDR_W-1:0] pretrig);
    return CNT_W'(DEPTH) - {1'b0, pretrig};
  endfunction

endpackage

// File: rtl/capture_ctrl_if.sv
// Control, sample and memory-write signals of the capture controller.
// slave is the controller side, master the side that drives it.
interface capture_ctrl_if;
  import capture_pkg::*;

  logic              arm;
  logic              force_trig;
  logic              trig_rising;
  logic [DATA_W-1:0] trig_level;
  logic [ADDR_W-1:0] pretrig;
  logic              adc_valid;
  logic [DATA_W-1:0] adc_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              dump_activate;
  logic              dump_done;
  logic [ADDR_W-1:0] start_addr;
  logic              busy;
  logic              triggered;

  modport master (
    output arm, force_trig, trig_rising, trig_level, pretrig, adc_valid, adc_data, dump_done,
    input  mem_we, mem_waddr, mem_wdata, dump_activate, start_addr, busy, triggered
  );

  modport slave (
    input  arm, force_trig, trig_rising, trig_level, pretrig, adc_valid, adc_data, dump_done,
    output mem_we, mem_waddr, mem_wdata, dump_activate, start_addr, busy, triggered
  );

endinterface

// File: rtl/trig_detect.sv
// Edge trigger detector: remembers the previous accepted sample and flags a threshold
// crossing on the current one. hit_o is combinational and lasts the sample's cycle.
module trig_detect
  import capture_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              sample_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] level_i,
  input  logic              rising_i,
  output logic              hit_o
);

  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic              rise_hit, fall_hit;

  always_comb begin
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    if (clear_i) begin
      prev_valid_d = 1'b0;
    end else if (sample_i) begin
      prev_d       = data_i;
      prev_valid_d = 1'b1;
    end
  end

  always_comb begin
    rise_hit = (prev_q < level_i) && (data_i >= level_i);
    fall_hit = (prev_q >= level_i) && (data_i < level_i);
    hit_o    = sample_i && prev_valid_q && (rising_i ? rise_hit : fall_hit);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Pre/post-trigger capture controller writing a 256-entry circular sample buffer.
// Define CAPTURE_AUTOTRIG_EN to force a trigger after 0.1 s spent waiting in ARMED.
module capture_ctrl
  import capture_pkg::*;
(
  input  logic           clk_50mhz,
  input  logic           reset,
  capture_ctrl_if.slave  bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] pretrig_q, pretrig_d;
  logic [DATA_W-1:0] level_q, level_d;
  logic              rising_q, rising_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic              triggered_q, triggered_d;

  logic accept, arm_take, hit, auto_trig, force_req;

  assign accept   = bus.adc_valid &&
                    (state_q inside {StPrefill, StArmed, StPost});
  assign arm_take = bus.arm && (state_q == StIdle);

  trig_detect u_trig_detect (
    .clk_i    (clk_50mhz),
    .rst_ni   (reset),
    .clear_i  (arm_take),
    .sample_i (accept),
    .data_i   (bus.adc_data),
    .level_i  (level_q),
    .rising_i (rising_q),
    .hit_o    (hit)
  );

`ifdef CAPTURE_AUTOTRIG_EN
  logic [AT_W-1:0] at_cnt_q, at_cnt_d;

  // Counter is held at zero outside ARMED, so every entry into ARMED starts from 0.
  always_comb begin
    at_cnt_d  = (state_q == StArmed) ? at_cnt_q + 1'b1 : '0;
    auto_trig = (state_q == StArmed) && (at_cnt_q == AT_W'(AUTOTRIG_CYCLES - 1));
  end

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      at_cnt_q <= '0;
    end else begin
      at_cnt_q <= at_cnt_d;
    end
  end
`else
  assign auto_trig = 1'b0;
`endif

  assign force_req = bus.force_trig || auto_trig;

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    cnt_d        = cnt_q;
    pretrig_d    = pretrig_q;
    level_d      = level_q;
    rising_d     = rising_q;
    mem_we_d     = 1'b0;
    mem_waddr_d  = mem_waddr_q;
    mem_wdata_d  = mem_wdata_q;
    start_addr_d = start_addr_q;
    triggered_d  = triggered_q;

    if (accept) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = wptr_q;
      mem_wdata_d = bus.adc_data;
      wptr_d      = wptr_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.arm) begin
          pretrig_d   = bus.pretrig;
          level_d     = bus.trig_level;
          rising_d    = bus.trig_rising;
          wptr_d      = '0;
          cnt_d       = '0;
          triggered_d = 1'b0;
          state_d     = (bus.pretrig != '0) ? StPrefill : StArmed;
        end
      end
      StPrefill: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == {1'b0, pretrig_q}) begin
            cnt_d   = '0;
            state_d = StArmed;
          end
        end
      end
      StArmed: begin
        if (hit) begin
          // The trigger sample itself is post-sample 1, written at wptr_q.
          start_addr_d = wptr_q - pretrig_q;
          triggered_d  = 1'b1;
          cnt_d        = CNT_W'(1);
          state_d      = (post_len(pretrig_q) == CNT_W'(1)) ? StDump : StPost;
        end else if (force_req) begin
          // Post-sample 1 is the next accepted sample, after any write this cycle.
          start_addr_d = wptr_d - pretrig_q;
          triggered_d  = 1'b1;
          cnt_d        = '0;
          state_d      = StPost;
        end
      end
      StPost: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == post_len(pretrig_q)) begin
            state_d = StDump;
          end
        end
      end
      StDump: begin
        if (bus.dump_done) begin
          triggered_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50mhz or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      wptr_q       <= '0;
      cnt_q        <= '0;
      pretrig_q    <= '0;
      level_q      <= '0;
      rising_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
      start_addr_q <= '0;
      triggered_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      cnt_q        <= cnt_d;
      pretrig_q    <= pretrig_d;
      level_q      <= level_d;
      rising_q     <= rising_d;
      mem_we_q     <= mem_we_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
      start_addr_q <= start_addr_d;
      triggered_q  <= triggered_d;
    end
  end

  assign bus.mem_we        = mem_we_q;
  assign bus.mem_waddr     = mem_waddr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.start_addr    = start_addr_q;
  assign bus.triggered     = triggered_q;
  assign bus.busy          = (state_q != StIdle);
  assign bus.dump_activate = (state_q == StDump);

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: expected memory writes are queued by the stimulus
// and popped by a negedge monitor; status outputs are checked directly.
module tb_capture_ctrl;
  import capture_pkg::*;

  logic clk_50mhz = 1'b0;
  logic reset     = 1'b0;

  capture_ctrl_if bus ();

  capture_ctrl dut (
    .clk_50mhz (clk_50mhz),
    .reset     (reset),
    .bus       (bus)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor
  always @(negedge clk_50mhz) begin
    wr_t e;
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write (t=%0t)",
                 bus.mem_waddr, bus.mem_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(bus.mem_waddr), 32'(e.addr));
        check("wr_data", 32'(bus.mem_wdata), 32'(e.data));
      end
    end
  end

  task automatic step();
    @(posedge clk_50mhz);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic sample(input logic [7:0] d, input bit expect_wr, input logic [7:0] addr);
    wr_t e;
    bus.adc_valid = 1'b1;
    bus.adc_data  = d;
    if (expect_wr) begin
      e.addr = addr;
      e.data = d;
      exp_q.push_back(e);
    end
    step();
    bus.adc_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [7:0] pre, input logic [7:0] lvl, input logic rising);
    bus.pretrig     = pre;
    bus.trig_level  = lvl;
    bus.trig_rising = rising;
    bus.arm         = 1'b1;
    step();
    bus.arm = 1'b0;
  endtask

  task automatic finish_dump(input string name);
    bus.dump_done = 1'b1;
    step();
    bus.dump_done = 1'b0;
    check({name, "_dump_off"}, 32'(bus.dump_activate), 32'd0);
    check({name, "_idle"}, 32'(bus.busy), 32'd0);
    check({name, "_trig_clr"}, 32'(bus.triggered), 32'd0);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    int cyc;
    bus.arm = 0; bus.force_trig = 0; bus.trig_rising = 0; bus.trig_level = 0;
    bus.pretrig = 0; bus.adc_valid = 0; bus.adc_data = 0; bus.dump_done = 0;

    // Reset state
    #5;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    idle(3);
    reset = 1'b1;
    check("init_dump", 32'(bus.dump_activate), 32'd0);
    check("init_start", 32'(bus.start_addr), 32'd0);
    check("init_trig", 32'(bus.triggered), 32'd0);
    for (int i = 0; i < 3; i++) sample(8'hAA, 1'b0, 8'h00);  // ignored in IDLE

    // Scenario 1: pretrig 16, rising at 0x80, ramp
    do_arm(8'd16, 8'h80, 1'b1);
    check("s1_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 368; i++) begin
      sample(8'(i), 1'b1, 8'(i));
      if (i == 127) check("s1_no_trig_yet", 32'(bus.triggered), 32'd0);
      if (i == 128) begin
        check("s1_triggered", 32'(bus.triggered), 32'd1);
        check("s1_start_addr", 32'(bus.start_addr), 32'h70);
      end
      if (i == 366) check("s1_no_dump_yet", 32'(bus.dump_activate), 32'd0);
    end
    check("s1_dump", 32'(bus.dump_activate), 32'd1);
    idle(2);
    check("s1_queue_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 3; i++) sample(8'h11, 1'b0, 8'h00);  // ignored in DUMP
    do_arm(8'd0, 8'h40, 1'b0);
    check("s1_arm_ign_busy", 32'(bus.busy), 32'd1);
    check("s1_arm_ign_dump", 32'(bus.dump_activate), 32'd1);
    lows = 0;
    repeat (1000) begin
      step();
      if (bus.dump_activate !== 1'b1) lows++;
    end
    check("s1_dump_hold_drops", 32'(lows), 32'd0);
    finish_dump("s1");

    // Scenario 2: pretrig 0, falling at 0x40
    do_arm(8'd0, 8'h40, 1'b0);
    check("s2_busy", 32'(bus.busy), 32'd1);
    sample(8'h50, 1'b1, 8'd0);
    check("s2_first_no_trig", 32'(bus.triggered), 32'd0);
    sample(8'h30, 1'b1, 8'd1);
    check("s2_triggered", 32'(bus.triggered), 32'd1);
    check("s2_start_addr", 32'(bus.start_addr), 32'd1);
    for (int k = 2; k <= 256; k++) begin
      if (k == 256) check("s2_no_dump_yet", 32'(bus.dump_activate), 32'd0);
      sample(8'h30, 1'b1, 8'(k));
    end
    check("s2_dump", 32'(bus.dump_activate), 32'd1);
    idle(2);
    check("s2_queue_empty", 32'(exp_q.size()), 32'd0);
    finish_dump("s2");

    // Scenario 3: constant input, force_trig
    do_arm(8'd4, 8'h80, 1'b1);
    sample(8'h10, 1'b1, 8'd0);
    sample(8'h10, 1'b1, 8'd1);
    bus.force_trig = 1'b1;
    step();
    bus.force_trig = 1'b0;
    check("s3_force_in_prefill", 32'(bus.triggered), 32'd0);
    for (int k = 2; k < 10; k++) sample(8'h10, 1'b1, 8'(k));
    check("s3_no_trig", 32'(bus.triggered), 32'd0);
    bus.force_trig = 1'b1;
    step();
    bus.force_trig = 1'b0;
    check("s3_triggered", 32'(bus.triggered), 32'd1);
    check("s3_start_addr", 32'(bus.start_addr), 32'd6);
    for (int k = 10; k < 262; k++) begin
      if (k == 261) check("s3_no_dump_yet", 32'(bus.dump_activate), 32'd0);
      sample(8'h10, 1'b1, 8'(k));
    end
    check("s3_dump", 32'(bus.dump_activate), 32'd1);
    idle(2);
    check("s3_queue_empty", 32'(exp_q.size()), 32'd0);
    finish_dump("s3");

    // Scenario 4: hit with force_trig in the same cycle, then reset mid-POST
    do_arm(8'd0, 8'h80, 1'b1);
    sample(8'h00, 1'b1, 8'd0);
    bus.force_trig = 1'b1;
    sample(8'h90, 1'b1, 8'd1);
    bus.force_trig = 1'b0;
    check("s4_start_addr", 32'(bus.start_addr), 32'd1);
    for (int k = 2; k < 9; k++) sample(8'h90, 1'b1, 8'(k));
    sample(8'h91, 1'b0, 8'd0);  // its write is still on the outputs when reset hits
    check("s4_pre_we", 32'(bus.mem_we), 32'd1);
    check("s4_pre_waddr", 32'(bus.mem_waddr), 32'd9);
    #4;
    reset = 1'b0;
    #1;
    check("s4_rst_we", 32'(bus.mem_we), 32'd0);
    check("s4_rst_waddr", 32'(bus.mem_waddr), 32'd0);
    check("s4_rst_wdata", 32'(bus.mem_wdata), 32'd0);
    check("s4_rst_dump", 32'(bus.dump_activate), 32'd0);
    check("s4_rst_start", 32'(bus.start_addr), 32'd0);
    check("s4_rst_busy", 32'(bus.busy), 32'd0);
    check("s4_rst_trig", 32'(bus.triggered), 32'd0);
    bus.adc_valid = 1'b1;
    bus.adc_data  = 8'h55;
    step();
    reset = 1'b1;
    idle(2);
    bus.adc_valid = 1'b0;
    check("s4_idle_after_rst", 32'(bus.busy), 32'd0);
    do_arm(8'd8, 8'h80, 1'b1);
    check("s4_rearm_busy", 32'(bus.busy), 32'd1);
    sample(8'h22, 1'b1, 8'd0);
    idle(2);
    check("s4_queue_empty", 32'(exp_q.size()), 32'd0);

`ifdef CAPTURE_AUTOTRIG_EN
    // Scenario 5: auto trigger after 5,000,000 cycles in ARMED
    reset = 1'b0;
    step();
    reset = 1'b1;
    do_arm(8'd0, 8'h80, 1'b1);
    cyc = 0;
    while (bus.triggered !== 1'b1 && cyc < 5000100) begin
      step();
      cyc++;
    end
    check("s5_autotrig_cycles", 32'(cyc), 32'd5000000);
`else
    cyc = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
